d_sram_like_slave: RTL and testbench

Responder end of the data-side SRAM-like interface: accepts one request at a time from the data-side SRAM-like initiator (data_req/data_wr/data_size/data_addr/data_wdata) and completes it against a synchronous single-port RAM with one-cycle read latency. It returns data_addr_ok and data_data_ok with a parameterised response delay, so it serves both as the on-chip data memory port and as the bench model for exercising initiator stall logic.

---
 rtl/d_sram_like_slave.sv | 107 ++++++++++
 tb/tb_d_sram_like_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/d_sram_like_slave.sv
// Single-outstanding SRAM-like responder in front of a synchronous RAM with
// one-cycle read latency; LAT adds wait cycles between address handshake and access.
module d_sram_like_slave #(
   parameter int LAT    = 0,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [31:0]       data_addr,
   input  logic [31:0]       data_wdata,
   output logic [31:0]       data_rdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic              ram_en,
   output logic [3:0]        ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;
   localparam logic [3:0] LAT_M1   = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        byte_en;

   // Address bits above the RAM window are deliberately dropped (wrap-around).
   logic unused_addr_hi;
   assign unused_addr_hi = ^data_addr[31:ADDR_W+2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (data_req) begin
               wr_d    = data_wr;
               size_d  = data_size;
               addr_d  = data_addr[ADDR_W+1:0];
               wdata_d = data_wdata;
               if (LAT > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = LAT_M1;
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ACCESS: state_d = S_RESP;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (size_q)
         2'b00:   byte_en = 4'b0001 << addr_q[1:0];
         2'b01:   byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign data_addr_ok = (state_q == S_IDLE);
   assign data_data_ok = (state_q == S_RESP);
   assign data_rdata   = (state_q == S_RESP && !wr_q) ? ram_rdata : 32'd0;
   assign ram_en       = (state_q == S_ACCESS);
   assign ram_wen      = (state_q == S_ACCESS && wr_q) ? byte_en : 4'b0000;
   assign ram_addr     = addr_q[ADDR_W+1:2];
   assign ram_wdata    = wdata_q;

endmodule

// File: tb/tb_d_sram_like_slave.sv
// Directed bench for d_sram_like_slave: three instances (LAT 0, LAT 3, LAT 2 with a
// 4-bit RAM) each backed by a behavioural byte-writable RAM with registered read.
module tb_d_sram_like_slave;

   logic        clk, rst, sel;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        req0, req2, req3;

   logic [31:0] rdata0, wd0, mrd0;
   logic        aok0, dok0, en0;
   logic [3:0]  wen0;
   logic [15:0] raddr0;

   logic [31:0] rdata2, wd2, mrd2;
   logic        aok2, dok2, en2;
   logic [3:0]  wen2;
   logic [3:0]  raddr2;

   logic [31:0] rdata3, wd3, mrd3;
   logic        aok3, dok3, en3;
   logic [3:0]  wen3;
   logic [15:0] raddr3;

   logic [31:0] mem0 [65536];
   logic [31:0] mem2 [16];
   logic [31:0] mem3 [65536];

   int n_cmp, n_err, hs, nd;

   d_sram_like_slave #(.LAT(0), .ADDR_W(16)) u_lat0 (
      .clk(clk), .rst(rst), .data_req(req0), .data_wr(wr), .data_size(size),
      .data_addr(addr), .data_wdata(wdata), .data_rdata(rdata0),
      .data_addr_ok(aok0), .data_data_ok(dok0), .ram_en(en0), .ram_wen(wen0),
      .ram_addr(raddr0), .ram_wdata(wd0), .ram_rdata(mrd0));

   d_sram_like_slave #(.LAT(2), .ADDR_W(4)) u_lat2 (
      .clk(clk), .rst(rst), .data_req(req2), .data_wr(wr), .data_size(size),
      .data_addr(addr), .data_wdata(wdata), .data_rdata(rdata2),
      .data_addr_ok(aok2), .data_data_ok(dok2), .ram_en(en2), .ram_wen(wen2),
      .ram_addr(raddr2), .ram_wdata(wd2), .ram_rdata(mrd2));

   d_sram_like_slave #(.LAT(3), .ADDR_W(16)) u_lat3 (
      .clk(clk), .rst(rst), .data_req(req3), .data_wr(wr), .data_size(size),
      .data_addr(addr), .data_wdata(wdata), .data_rdata(rdata3),
      .data_addr_ok(aok3), .data_data_ok(dok3), .ram_en(en3), .ram_wen(wen3),
      .ram_addr(raddr3), .ram_wdata(wd3), .ram_rdata(mrd3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (en0) begin
         for (int i = 0; i < 4; i++)
            if (wen0[i]) mem0[raddr0][8*i +: 8] <= wd0[8*i +: 8];
         mrd0 <= mem0[raddr0];
      end
      if (en2) begin
         for (int i = 0; i < 4; i++)
            if (wen2[i]) mem2[raddr2][8*i +: 8] <= wd2[8*i +: 8];
         mrd2 <= mem2[raddr2];
      end
      if (en3) begin
         for (int i = 0; i < 4; i++)
            if (wen3[i]) mem3[raddr3][8*i +: 8] <= wd3[8*i +: 8];
         mrd3 <= mem3[raddr3];
      end
   end

   // sel chooses which of the LAT0 / LAT2 instances the transaction task drives
   logic [31:0] o_rdata, o_wd;
   logic        o_aok, o_dok, o_en;
   logic [3:0]  o_wen;
   logic [15:0] o_raddr;
   assign o_rdata = sel ? rdata2 : rdata0;
   assign o_wd    = sel ? wd2 : wd0;
   assign o_aok   = sel ? aok2 : aok0;
   assign o_dok   = sel ? dok2 : dok0;
   assign o_en    = sel ? en2 : en0;
   assign o_wen   = sel ? wen2 : wen0;
   assign o_raddr = sel ? {12'd0, raddr2} : raddr0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic xact(input string tag, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] e_wen, input logic [15:0] e_raddr,
                       input logic [31:0] e_rdata);
      int lat;
      lat = sel ? 2 : 0;
      wr = w; size = s; addr = a; wdata = d;
      if (sel) req2 = 1'b1; else req0 = 1'b1;
      chk({tag, ".aok_hs"}, 32'(o_aok), 32'd1);
      step();
      req0 = 1'b0; req2 = 1'b0;
      wr = ~w; size = ~s; addr = 32'hFFFF_FFFF; wdata = ~d;
      repeat (lat) begin
         chk({tag, ".aok_wait"}, 32'(o_aok), 32'd0);
         chk({tag, ".en_wait"}, 32'(o_en), 32'd0);
         step();
      end
      chk({tag, ".en"}, 32'(o_en), 32'd1);
      chk({tag, ".wen"}, 32'(o_wen), 32'(e_wen));
      chk({tag, ".raddr"}, 32'(o_raddr), 32'(e_raddr));
      chk({tag, ".wdata"}, o_wd, d);
      chk({tag, ".aok_acc"}, 32'(o_aok), 32'd0);
      chk({tag, ".dok_acc"}, 32'(o_dok), 32'd0);
      step();
      chk({tag, ".dok"}, 32'(o_dok), 32'd1);
      chk({tag, ".rdata"}, o_rdata, e_rdata);
      chk({tag, ".en_resp"}, 32'(o_en), 32'd0);
      chk({tag, ".aok_resp"}, 32'(o_aok), 32'd0);
      step();
      chk({tag, ".aok_back"}, 32'(o_aok), 32'd1);
      chk({tag, ".dok_back"}, 32'(o_dok), 32'd0);
      $display("xact %s wr=%0d size=%0d addr=%h wdata=%h rdata=%h", tag, w, s, a, d, e_rdata);
   endtask

   logic [5:0] e_aok, e_en, e_dok;

   initial begin
      n_cmp = 0; n_err = 0;
      rst = 1'b1; sel = 1'b0; req0 = 1'b0; req2 = 1'b0; req3 = 1'b0;
      wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
      for (int i = 0; i < 65536; i++) begin
         mem0[i] = 32'd0;
         mem3[i] = 32'd0;
      end
      for (int i = 0; i < 16; i++) mem2[i] = 32'd0;
      mem3[5] = 32'hCAFE_F00D;
      step();
      step();

      chk("rst.aok", 32'(aok0), 32'd1);
      chk("rst.dok", 32'(dok0), 32'd0);
      chk("rst.rdata", rdata0, 32'd0);
      chk("rst.en", 32'(en0), 32'd0);
      chk("rst.wen", 32'(wen0), 32'd0);
      chk("rst.raddr", 32'(raddr0), 32'd0);
      chk("rst.wdata", wd0, 32'd0);
      chk("rst.aok2", 32'(aok2), 32'd1);
      chk("rst.aok3", 32'(aok3), 32'd1);
      $display("xact reset");
      rst = 1'b0;
      step();

      xact("w10", 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 4'b1111, 16'd4, 32'd0);
      xact("r10", 1'b0, 2'b10, 32'h10, 32'h0, 4'b0000, 16'd4, 32'hDEAD_BEEF);
      xact("wb21", 1'b1, 2'b00, 32'h21, 32'h0000_AA00, 4'b0010, 16'd8, 32'd0);
      xact("wb22", 1'b1, 2'b00, 32'h22, 32'h00BB_0000, 4'b0100, 16'd8, 32'd0);
      xact("wb23", 1'b1, 2'b00, 32'h23, 32'hCC00_0000, 4'b1000, 16'd8, 32'd0);
      xact("wh22", 1'b1, 2'b01, 32'h22, 32'h5566_0000, 4'b1100, 16'd8, 32'd0);
      xact("r20", 0, 2'b10, 32'h20, 32'h0, 4'b0000, 16'd8, 32'h5566_AA00);
      xact("ws3_23", 1'b1, 2'b11, 32'h23, 32'h0102_0304, 4'b1111, 16'd8, 32'd0);
      xact("rb23", 1'b0, 2'b00, 32'h23, 32'h0, 4'b0000, 16'd8, 32'h0102_0304);

      // LAT=3 read: handshake in cycle h, then cycles h+1..h+6
      e_aok = 6'b100000;
      e_en  = 6'b001000;
      e_dok = 6'b010000;
      wr = 1'b0; size = 2'b10; addr = 32'h14; req3 = 1'b1;
      chk("l3.aok_hs", 32'(aok3), 32'd1);
      step();
      req3 = 1'b0; addr = 32'h0;
      for (int k = 1; k <= 6; k++) begin
         chk($sformatf("l3.aok@h+%0d", k), 32'(aok3), 32'(e_aok[k-1]));
         chk($sformatf("l3.en@h+%0d", k), 32'(en3), 32'(e_en[k-1]));
         chk($sformatf("l3.dok@h+%0d", k), 32'(dok3), 32'(e_dok[k-1]));
         if (k == 4) chk("l3.raddr", 32'(raddr3), 32'd5);
         if (k == 5) chk("l3.rdata", rdata3, 32'hCAFE_F00D);
         if (k < 6) step();
      end
      $display("xact lat3 read addr=00000014 rdata=cafef00d");

      // back-to-back with data_req held high on the LAT=3 instance
      hs = 0; nd = 0;
      addr = 32'h14; req3 = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (aok3) begin
            chk("b2b.hs_cycle", 32'(k), 32'(hs * 6));
            hs++;
         end
         if (dok3) nd++;
         chk("b2b.aok_dok_excl", 32'(aok3 & dok3), 32'd0);
         step();
      end
      req3 = 1'b0;
      chk("b2b.hs_count", 32'(hs), 32'd4);
      chk("b2b.dok_count", 32'(nd), 32'd3);
      for (int k = 0; k < 10 && !aok3; k++) step();
      chk("b2b.drain", 32'(aok3), 32'd1);
      $display("xact lat3 back-to-back handshakes=%0d completions=%0d", hs, nd);

      // reset during the WAIT phase of a LAT=2 write
      sel = 1'b1;
      wr = 1'b1; size = 2'b10; addr = 32'h8; wdata = 32'h1111_1111; req2 = 1'b1;
      chk("rmid.aok_hs", 32'(aok2), 32'd1);
      step();
      req2 = 1'b0;
      chk("rmid.en_h1", 32'(en2), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rmid.aok", 32'(aok2), 32'd1);
      chk("rmid.dok", 32'(dok2), 32'd0);
      chk("rmid.en", 32'(en2), 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rmid.dok_after", 32'(dok2), 32'd0);
         chk("rmid.en_after", 32'(en2), 32'd0);
      end
      chk("rmid.ram_word", mem2[2], 32'd0);
      $display("xact reset-mid-write addr=00000008 ram=%h", mem2[2]);

      xact("wwrap40", 1'b1, 2'b10, 32'h40, 32'h1234_5678, 4'b1111, 16'd0, 32'd0);
      xact("rwrap00", 1'b0, 2'b10, 32'h00, 32'h0, 4'b0000, 16'd0, 32'h1234_5678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
